// File: rtl/color_pick_pkg.sv
// Shared render definitions: colour-map field layout, pick FSM states and result record.
package color_pick_pkg;

    localparam int unsigned INTW = 12;
    localparam int unsigned PIXLW = 12;

    // Colour word layout: {y[6:1], x[6:1]}; each field drops coordinate bit 0.
    localparam int unsigned X_LSB       = 0;
    localparam int unsigned Y_LSB       = 6;
    localparam int unsigned FIELD_W     = 6;
    localparam int unsigned COORD_SHIFT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StScan,
        StDone
    } pick_state_t;

    typedef struct packed {
        logic [INTW-1:0] x;
        logic [INTW-1:0] y;
    } coord_t;

    typedef struct packed {
        logic             err;
        logic [PIXLW-1:0] color;
        coord_t           pos;
    } pick_res_t;

    // Forward map used by the colour generator: coordinate to colour.
    function automatic logic [PIXLW-1:0] coord_to_color(input logic [INTW-1:0] x,
                                                         input logic [INTW-1:0] y);
        logic [PIXLW-1:0] c;
        c = '0;
        c[X_LSB +: FIELD_W] = x[COORD_SHIFT +: FIELD_W];
        c[Y_LSB +: FIELD_W] = y[COORD_SHIFT +: FIELD_W];
        return c;
    endfunction

endpackage

// File: rtl/color_pick_if.sv
// Pick request/result and raster-stream signals between framebuffer, UI and the picker.
interface color_pick_if;
    import color_pick_pkg::*;

    logic             frame_start;
    logic             scan_de;
    logic [INTW-1:0]  scan_x;
    logic [INTW-1:0]  scan_y;
    logic [PIXLW-1:0] pix_color;
    logic [INTW-1:0]  sx;
    logic [INTW-1:0]  sy;
    logic             req;
    logic             ack;
    logic             busy;
    logic             valid;
    logic             err;
    logic [INTW-1:0]  pick_x;
    logic [INTW-1:0]  pick_y;
    logic [PIXLW-1:0] pick_color;

    modport slave (
        input  frame_start, scan_de, scan_x, scan_y, pix_color, sx, sy, req, ack,
        output busy, valid, err, pick_x, pick_y, pick_color
    );

    modport master (
        output frame_start, scan_de, scan_x, scan_y, pix_color, sx, sy, req, ack,
        input  busy, valid, err, pick_x, pick_y, pick_color
    );

endinterface

// File: rtl/color_decode.sv
// Colour word back to the even coordinate it encodes; pure bit-select, also used by overlays.
module color_decode
    import color_pick_pkg::*;
(
    input  logic [PIXLW-1:0] i_color,
    output coord_t           o_pos
);

    // Zero-extend each field into its coordinate, leaving bit 0 clear.
    always_comb begin
        o_pos = '0;
        o_pos.x[COORD_SHIFT +: FIELD_W] = i_color[X_LSB +: FIELD_W];
        o_pos.y[COORD_SHIFT +: FIELD_W] = i_color[Y_LSB +: FIELD_W];
    end

endmodule

// File: rtl/color_pick.sv
// Colour-map readback: samples the stream at a latched cursor once per frame and reports
// the decoded coordinate after STABLE matching frames, or an error after MISS_LIMIT misses.
module color_pick
    import color_pick_pkg::*;
#(
    parameter int unsigned PIX_LAT    = 2,
    parameter int unsigned STABLE     = 3,
    parameter int unsigned MISS_LIMIT = 4
) (
    input logic         clk,
    input logic         rst,
    color_pick_if.slave bus
);

    localparam int unsigned CNT_MAX = (STABLE > MISS_LIMIT) ? STABLE : MISS_LIMIT;
    localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CNTW-1:0] STABLE_C = CNTW'(STABLE);
    localparam logic [CNTW-1:0] MISS_C   = CNTW'(MISS_LIMIT);
    localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
    endfunction

    pick_state_t      r_state, w_state_nxt;
    logic [INTW-1:0]  r_sx, r_sy;
    logic [CNTW-1:0]  r_stable, r_miss;
    logic [PIXLW-1:0] r_prev;   // sample of the last frame that had a hit
    logic [PIXLW-1:0] r_samp;   // sample captured in the current frame
    logic             r_got;    // current frame already has its one hit
    pick_res_t        r_res;

    logic             w_accept, w_in_scan, w_feed, w_hit, w_hit_dly, w_cap, w_eval;
    logic             w_frame_hit, w_same, w_done_ok, w_done_err;
    logic [PIXLW-1:0] w_cur;
    logic [CNTW-1:0]  w_stable_nxt, w_miss_nxt;
    coord_t           w_dec;

    assign w_accept  = (r_state == StIdle) && bus.req;
    assign w_in_scan = (r_state == StScan);
    // The arming frame_start cycle already belongs to the first sampled frame.
    assign w_feed    = w_in_scan || ((r_state == StArm) && bus.frame_start);
    assign w_hit     = bus.scan_de && (bus.scan_x == r_sx) && (bus.scan_y == r_sy);

    if (PIX_LAT == 0) begin : g_no_dly
        assign w_hit_dly = w_hit && w_feed;
    end else begin : g_dly
        logic [PIX_LAT-1:0] r_dly;

        // Align the hit flag with the colour returned PIX_LAT cycles later.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dly <= '0;
            end else if (w_accept) begin
                r_dly <= '0;
            end else begin
                r_dly[0] <= w_hit && w_feed;
                for (int i = 1; i < PIX_LAT; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign w_hit_dly = r_dly[PIX_LAT-1];
    end

    // A delayed hit coinciding with frame_start still counts for the frame that is ending.
    assign w_cap        = w_in_scan && w_hit_dly && !r_got;
    assign w_eval       = w_in_scan && bus.frame_start;
    assign w_frame_hit  = r_got || (w_in_scan && w_hit_dly);
    assign w_cur        = r_got ? r_samp : bus.pix_color;
    assign w_same       = (r_stable != '0) && (w_cur == r_prev);
    assign w_stable_nxt = w_frame_hit ? (w_same ? sat_inc(r_stable) : ONE_C) : '0;
    assign w_miss_nxt   = w_frame_hit ? '0 : sat_inc(r_miss);
    assign w_done_ok    = w_eval && w_frame_hit && (w_stable_nxt >= STABLE_C);
    assign w_done_err   = w_eval && !w_frame_hit && (w_miss_nxt >= MISS_C);

    color_decode u_decode (
        .i_color (w_cur),
        .o_pos   (w_dec)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = 1'b0;
        bus.valid   = 1'b0;
        bus.err     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req) w_state_nxt = StArm;
            end
            StArm: begin
                bus.busy = 1'b1;
                if (bus.frame_start) w_state_nxt = StScan;
            end
            StScan: begin
                bus.busy = 1'b1;
                if (w_done_ok || w_done_err) w_state_nxt = StDone;
            end
            StDone: begin
                bus.valid = 1'b1;
                bus.err   = r_res.err;
                if (bus.ack) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Cursor latch, per-frame capture, stability/miss counters and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sx     <= '0;
            r_sy     <= '0;
            r_stable <= '0;
            r_miss   <= '0;
            r_prev   <= '0;
            r_samp   <= '0;
            r_got    <= 1'b0;
            r_res    <= '0;
        end else begin
            if (w_accept) begin
                r_sx     <= bus.sx;
                r_sy     <= bus.sy;
                r_stable <= '0;
                r_miss   <= '0;
                r_prev   <= '0;
                r_samp   <= '0;
                r_got    <= 1'b0;
            end
            if (w_cap) begin
                r_got  <= 1'b1;
                r_samp <= bus.pix_color;
            end
            if (w_eval) begin
                r_got    <= 1'b0;
                r_stable <= w_stable_nxt;
                r_miss   <= w_miss_nxt;
                if (w_frame_hit) r_prev <= w_cur;
            end
            if (w_done_ok) begin
                r_res.err   <= 1'b0;
                r_res.color <= w_cur;
                r_res.pos   <= w_dec;
            end
            if (w_done_err) begin
                r_res <= '0;
                r_res.err <= 1'b1;
            end
        end
    end

    assign bus.pick_x     = r_res.pos.x;
    assign bus.pick_y     = r_res.pos.y;
    assign bus.pick_color = r_res.color;

endmodule
